ldq_req_scheduler: RTL and testbench

LDQ_REQ_SCHEDULER -- requirements
Module: ldq_req_scheduler

---
 rtl/ldq_req_scheduler_pkg.sv | 13 +
 rtl/ldq_order_fifo.sv | 44 ++++
 rtl/ldq_req_scheduler.sv | 131 +++++++++++++
 tb/tb_ldq_req_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldq_req_scheduler_pkg.sv
// Shared constants for the load-queue request scheduler.
package ldq_req_scheduler_pkg;

    localparam int SPMV_BEATS_PER_REQ = 32;  // 2KB burst of 64B beats
    localparam int SPMV_CREDITS       = 2;
    localparam int SPMV_ID_WIDTH      = 9;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ldq_order_fifo.sv
// Order FIFO: remembers which requester owns each outstanding burst.
module ldq_order_fifo
    import ldq_req_scheduler_pkg::*;
#(
    parameter int ENTRY_W = 2,
    parameter int PTR_W   = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rstn,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH = 1 << PTR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wr_ptr, rd_ptr;

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    // Pointers; the extra MSB disambiguates full from empty.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ldq_req_scheduler.sv
// Round-robin request scheduler in front of the load queue, with per-requester
// credits and in-order routing of returned data bursts.
module ldq_req_scheduler
    import ldq_req_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_WIDTH      = SPMV_ID_WIDTH,
    parameter int DATA_WIDTH    = 512,
    parameter int BEATS_PER_REQ = SPMV_BEATS_PER_REQ,
    parameter int CREDITS       = SPMV_CREDITS,
    parameter int ORD_PTR_WIDTH = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rstn,
    input  logic [NUM_REQ-1:0]           rq_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]  rq_id,
    output logic [NUM_REQ-1:0]           rq_ready,
    output logic                         ldq_req_valid,
    output logic [ID_WIDTH-1:0]          ldq_req_id,
    input  logic                         ldq_req_ready,
    input  logic                         ldq_data_valid,
    output logic                         ldq_data_ready,
    input  logic [DATA_WIDTH-1:0]        ldq_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_last,
    output logic                         proto_err
);

    localparam int RR_W   = clog2_min1(NUM_REQ);
    localparam int BEAT_W = clog2_min1(BEATS_PER_REQ);
    localparam int CRED_W = $clog2(CREDITS + 1);

    logic [NUM_REQ-1:0][ID_WIDTH-1:0] rq_id_arr;
    logic [NUM_REQ-1:0][CRED_W-1:0]   credit;
    logic [NUM_REQ-1:0]               eligible;
    logic [RR_W-1:0]                  rr_ptr, grant_idx, cand, head;
    logic [BEAT_W-1:0]                beat_cnt;
    logic                             grant_vld, can_load, fifo_full, fifo_empty;
    logic                             beat_xfer, last_beat, pop;

    assign rq_id_arr = rq_id;
    assign can_load  = !ldq_req_valid || ldq_req_ready;

    // Data side: the FIFO head owns the current burst.
    assign ldq_data_ready = !fifo_empty && rsp_ready[head];
    assign beat_xfer      = ldq_data_valid && ldq_data_ready;
    assign last_beat      = (beat_cnt == BEAT_W'(BEATS_PER_REQ - 1));
    assign pop            = beat_xfer && last_beat;
    assign rsp_last       = last_beat;
    assign rsp_data       = ldq_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic take, give;
            assign eligible[gi]  = rq_valid[gi] && (credit[gi] != '0) && (!fifo_full || pop);
            assign rq_ready[gi]  = grant_vld && (grant_idx == RR_W'(gi));
            assign rsp_valid[gi] = ldq_data_valid && !fifo_empty && (head == RR_W'(gi));
            assign take          = rq_ready[gi];
            assign give          = pop && (head == RR_W'(gi));

            // Credit counter: a simultaneous grant and return cancel out.
            always_ff @(posedge sys_clk or negedge sys_rstn) begin
                if (!sys_rstn) begin
                    credit[gi] <= CRED_W'(CREDITS);
                end else if (take && !give && credit[gi] != '0) begin
                    credit[gi] <= credit[gi] - 1'b1;
                end else if (give && !take && credit[gi] != CRED_W'(CREDITS)) begin
                    credit[gi] <= credit[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin pick of the first eligible requester at or after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_vld && can_load && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Output request register and round-robin pointer.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            ldq_req_valid <= 1'b0;
            ldq_req_id    <= '0;
            rr_ptr        <= '0;
        end else if (grant_vld) begin
            ldq_req_valid <= 1'b1;
            ldq_req_id    <= rq_id_arr[grant_idx];
            rr_ptr        <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (ldq_req_ready) begin
            ldq_req_valid <= 1'b0;
        end
    end

    // Beat counter within the current burst, and sticky protocol error.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (beat_xfer) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (ldq_data_valid && fifo_empty) proto_err <= 1'b1;
        end
    end

    ldq_order_fifo #(
        .ENTRY_W (RR_W),
        .PTR_W   (ORD_PTR_WIDTH)
    ) u_order_fifo (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .push      (grant_vld),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ldq_req_scheduler.sv
// Bench for ldq_req_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ldq_req_scheduler;

    localparam int N   = 4;
    localparam int IDW = 9;
    localparam int DW  = 512;
    localparam int B   = 32;
    localparam int C   = 2;

    logic               sys_clk = 1'b0;
    logic               sys_rstn = 1'b0;
    logic [N-1:0]       rq_valid = '0;
    logic [N*IDW-1:0]   rq_id = '0;
    logic [N-1:0]       rq_ready;
    logic               ldq_req_valid;
    logic [IDW-1:0]     ldq_req_id;
    logic               ldq_req_ready = 1'b0;
    logic               ldq_data_valid = 1'b0;
    logic               ldq_data_ready;
    logic [DW-1:0]      ldq_data = '0;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready = '0;
    logic [DW-1:0]      rsp_data;
    logic               rsp_last;
    logic               proto_err;

    always #5 sys_clk = ~sys_clk;

    ldq_req_scheduler dut (
        .sys_clk        (sys_clk),
        .sys_rstn       (sys_rstn),
        .rq_valid       (rq_valid),
        .rq_id          (rq_id),
        .rq_ready       (rq_ready),
        .ldq_req_valid  (ldq_req_valid),
        .ldq_req_id     (ldq_req_id),
        .ldq_req_ready  (ldq_req_ready),
        .ldq_data_valid (ldq_data_valid),
        .ldq_data_ready (ldq_data_ready),
        .ldq_data       (ldq_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_last       (rsp_last),
        .proto_err      (proto_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: owner queue, credits, pointer, request reg, beat, error.
    int             m_q[$];
    int             m_cred[N];
    int             m_rr;
    bit             m_vld;
    logic [IDW-1:0] m_id;
    int             m_beat;
    bit             m_err;

    // Observed outputs of the latest sampled cycle, for literal checks.
    logic [N-1:0]   o_rq_ready, o_rsp_valid;
    logic           o_ldr, o_last, o_vld, o_err;
    logic [IDW-1:0] o_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < N; i++) m_cred[i] = C;
        m_rr = 0; m_vld = 0; m_id = '0; m_beat = 0; m_err = 0;
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic check_and_advance();
        bit has, ldr, pop, canl;
        int head, g;
        logic [N-1:0] exp_rqr, exp_rv;
        has  = (m_q.size() > 0);
        head = has ? m_q[0] : 0;
        ldr  = has && rsp_ready[head];
        exp_rv = '0;
        if (ldq_data_valid && has) exp_rv[head] = 1'b1;
        pop  = ldq_data_valid && ldr && (m_beat == B - 1);
        canl = !m_vld || ldq_req_ready;
        g = -1;
        if (canl && (m_q.size() < 16 || pop))
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (g < 0 && rq_valid[idx] && m_cred[idx] > 0) g = idx;
            end
        exp_rqr = '0;
        if (g >= 0) exp_rqr[g] = 1'b1;

        o_rq_ready = rq_ready; o_rsp_valid = rsp_valid; o_ldr = ldq_data_ready;
        o_last = rsp_last; o_vld = ldq_req_valid; o_id = ldq_req_id; o_err = proto_err;

        chk("rq_ready", rq_ready, exp_rqr);
        chk("ldq_req_valid", ldq_req_valid, m_vld);
        chk("ldq_req_id", ldq_req_id, m_id);
        chk("ldq_data_ready", ldq_data_ready, ldr);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_last", rsp_last, (m_beat == B - 1));
        chk("proto_err", proto_err, m_err);
        checks++;
        if (rsp_data !== ldq_data) begin
            failures++;
            $display("FAIL rsp_data: got %0h expected %0h", rsp_data[63:0], ldq_data[63:0]);
        end

        if (sys_rstn) begin
            if (ldq_data_valid && !has) m_err = 1;
            if (ldq_data_valid && ldr) begin
                if (m_beat == B - 1) begin
                    m_beat = 0;
                    m_cred[head]++;
                    void'(m_q.pop_front());
                end else begin
                    m_beat++;
                end
            end
            if (g >= 0) begin
                m_vld = 1;
                m_id  = rq_id[g*IDW +: IDW];
                m_q.push_back(g);
                m_cred[g]--;
                m_rr = (g + 1) % N;
            end else if (ldq_req_ready) begin
                m_vld = 0;
            end
        end
    endtask

    // One clock: inputs already set after a falling edge.
    task automatic cycle();
        #1;
        check_and_advance();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rstn = 1'b0;
        rq_valid = '0;
        ldq_data_valid = 1'b0;
        model_reset();
        cycle();
        cycle();
        sys_rstn = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
        return -1;
    endfunction

    initial begin
        int exp_order[5];
        int grants;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) rq_id[i*IDW +: IDW] = IDW'(9'h10 + i);
        rsp_ready = '1;
        @(negedge sys_clk);

        // Round-robin with every requester valid.
        do_reset();
        rq_valid = '1; ldq_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("rr_order", onehot_idx(o_rq_ready), exp_order[c]);
            if (c > 0) chk("req_id_latency", o_id, 9'h10 + exp_order[c-1]);
        end

        // Credit exhaustion on requester 2, released by the last beat.
        do_reset();
        rq_valid = 4'b0100; ldq_req_ready = 1'b1;
        cycle(); chk("cred_grant1", o_rq_ready[2], 1);
        cycle(); chk("cred_grant2", o_rq_ready[2], 1);
        cycle(); chk("cred_block", o_rq_ready[2], 0);
        ldq_data_valid = 1'b1;
        for (int b = 0; b < B; b++) begin
            ldq_data = DW'(b);
            cycle();
            chk("cred_still_block", o_rq_ready[2], 0);
        end
        ldq_data_valid = 1'b0;
        cycle(); chk("cred_release", o_rq_ready[2], 1);

        // Two bursts routed to requesters 1 then 3.
        do_reset();
        rq_valid = 4'b0010; cycle();
        rq_valid = 4'b1000; cycle();
        rq_valid = '0; ldq_data_valid = 1'b1;
        for (int b = 0; b < 2*B; b++) begin
            ldq_data = {16{$urandom}};
            cycle();
            chk("route", o_rsp_valid, (b < B) ? 4'b0010 : 4'b1000);
            chk("route_last", o_last, (b % B) == B - 1);
        end
        ldq_data_valid = 1'b0;

        // Back-pressure mid-burst keeps the beat count.
        do_reset();
        rq_valid = 4'b0001; cycle();
        rq_valid = '0; ldq_data_valid = 1'b1;
        for (int b = 0; b < 10; b++) cycle();
        rsp_ready = '0;
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("stall_ready", o_ldr, 0);
            chk("stall_valid", o_rsp_valid, 4'b0001);
        end
        rsp_ready = '1;
        for (int b = 0; b < B - 10; b++) begin
            cycle();
            chk("stall_last", o_last, b == B - 11);
        end
        ldq_data_valid = 1'b0;
        cycle(); chk("stall_done", o_rsp_valid, 0);

        // Data with no outstanding request sets a sticky error.
        do_reset();
        ldq_data_valid = 1'b1; cycle();
        ldq_data_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("proto_err_sticky", o_err, 1);
        end
        do_reset();
        chk("proto_err_cleared", o_err, 0);

        // Reset in the middle of a burst.
        rq_valid = 4'b0100; cycle();
        rq_valid = '0; ldq_data_valid = 1'b1;
        for (int b = 0; b < 10; b++) cycle();
        do_reset();
        chk("midreset_vld", o_vld, 0);
        ldq_data_valid = 1'b1; cycle();
        chk("midreset_no_rsp", o_rsp_valid, 0);
        ldq_data_valid = 1'b0;
        rq_valid = 4'b0100;
        grants = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (o_rq_ready[2]) grants++;
        end
        chk("midreset_credits", grants, C);
        rq_valid = '0;

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(999) == 0) do_reset();
            rq_valid = N'($urandom);
            rq_id = {N*IDW{1'b0}} | {$urandom, $urandom};
            ldq_req_ready = ($urandom_range(3) != 0);
            rsp_ready = N'($urandom) | N'($urandom);
            ldq_data = {16{$urandom}};
            ldq_data_valid = (m_q.size() > 0) ? ($urandom_range(3) != 0)
                                              : ($urandom_range(49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
